// File: rtl/cpu_issue_ctrl.sv
// Round-robin issue controller: hands one instruction at a time to cpu_top and returns its result.
// Optional WAIT-state timeout is enabled by defining CPU_ISSUE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | parked on NOP, granting one requester
// ISSUE | latched instruction driven, done ignored (may be stale)
// WAIT  | instruction held until done (or timeout)
// RESP  | one-cycle response strobe, back to NOP
module cpu_issue_ctrl #(
  parameter logic [7:0] NOP_OPCODE = 8'hF0
`ifdef CPU_ISSUE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_instr,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_instr,
  output logic       req1_ready,
  output logic [7:0] cpu_instr,
  input  logic [7:0] cpu_result,
  input  logic       cpu_done,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_timeout,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic       last;
  logic       id_q;
  logic [7:0] instr_q;
  logic       gnt0, gnt1;
  logic       tmo_hit;

  // The requester not served last time wins a tie; last resets to 1 so requester 0 goes first.
  assign gnt0 = req0_valid && (!req1_valid || last);
  assign gnt1 = req1_valid && (!req0_valid || !last);

`ifdef CPU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       tmo_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 8'h00;
    end else if (state == ISSUE) begin
      wait_cnt <= 8'h00;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Limit is reached on the edge that ends the TIMEOUT_CYCLES-th WAIT cycle; done wins a tie.
  assign tmo_hit = (state == WAIT) && !cpu_done && (wait_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= 1'b0;
    end else if (state == WAIT && cpu_done) begin
      tmo_q <= 1'b0;
    end else if (tmo_hit) begin
      tmo_q <= 1'b1;
    end
  end

  assign rsp_timeout = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cpu_instr  = NOP_OPCODE;
    case (state)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) state_nxt = ISSUE;
      end
      ISSUE: begin
        cpu_instr = instr_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        cpu_instr = instr_q;
        if (cpu_done || tmo_hit) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last    <= 1'b1;
      id_q    <= 1'b0;
      instr_q <= 8'h00;
    end else if (state == IDLE && (gnt0 || gnt1)) begin
      last    <= gnt1;
      id_q    <= gnt1;
      instr_q <= gnt0 ? req0_instr : req1_instr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= 8'h00;
    end else if (state == WAIT && cpu_done) begin
      rsp_id     <= id_q;
      rsp_result <= cpu_result;
    end else if (tmo_hit) begin
      rsp_id     <= id_q;
      rsp_result <= 8'h00;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Directed bench for cpu_issue_ctrl: single request, contention with stale done,
// reset in WAIT, and timeout (or indefinite wait when CPU_ISSUE_TIMEOUT_EN is undefined).
module tb_cpu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_instr, req1_instr;
  logic       req0_ready, req1_ready;
  logic [7:0] cpu_instr;
  logic [7:0] cpu_result;
  logic       cpu_done;
  logic       rsp_valid, rsp_id, rsp_timeout, busy;
  logic [7:0] rsp_result;

  int checks = 0;
  int failures = 0;

  cpu_issue_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_instr (req0_instr),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_instr (req1_instr),
    .req1_ready (req1_ready),
    .cpu_instr  (cpu_instr),
    .cpu_result (cpu_result),
    .cpu_done   (cpu_done),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_timeout(rsp_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_slot();
    #3;
  endtask

  initial begin
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_instr = 8'h00;
    req1_instr = 8'h00;
    cpu_result = 8'h00;
    cpu_done   = 1'b0;
    #2;
    chk("rst_cpu_instr", 16'(cpu_instr), 16'hF0);
    chk("rst_ready0", 16'(req0_ready), 16'h0);
    chk("rst_ready1", 16'(req1_ready), 16'h0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_rsp_id", 16'(rsp_id), 16'h0);
    chk("rst_rsp_result", 16'(rsp_result), 16'h00);
    chk("rst_rsp_timeout", 16'(rsp_timeout), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);

    // ---- single request from requester 0 ----
    drive_slot();
    reset_n = 1'b1;
    drive_slot();
    req0_valid = 1'b1;
    req0_instr = 8'h01;
    sample_slot();
    chk("s_ready0", 16'(req0_ready), 16'h1);
    chk("s_ready1", 16'(req1_ready), 16'h0);
    chk("s_idle_instr", 16'(cpu_instr), 16'hF0);
    drive_slot();
    req0_valid = 1'b0;
    sample_slot();
    chk("s_issue_instr", 16'(cpu_instr), 16'h01);
    chk("s_issue_busy", 16'(busy), 16'h1);
    chk("s_issue_ready0", 16'(req0_ready), 16'h0);
    drive_slot();
    cpu_done   = 1'b1;
    cpu_result = 8'h2A;
    sample_slot();
    chk("s_wait_instr", 16'(cpu_instr), 16'h01);
    chk("s_wait_rsp_valid", 16'(rsp_valid), 16'h0);
    drive_slot();
    cpu_done = 1'b0;
    sample_slot();
    chk("s_resp_valid", 16'(rsp_valid), 16'h1);
    chk("s_resp_id", 16'(rsp_id), 16'h0);
    chk("s_resp_result", 16'(rsp_result), 16'h2A);
    chk("s_resp_timeout", 16'(rsp_timeout), 16'h0);
    chk("s_resp_instr", 16'(cpu_instr), 16'hF0);
    drive_slot();
    sample_slot();
    chk("s_after_valid", 16'(rsp_valid), 16'h0);
    chk("s_after_busy", 16'(busy), 16'h0);
    chk("s_after_result_hold", 16'(rsp_result), 16'h2A);

    // ---- contention with done held high (stale done in ISSUE) ----
    drive_slot();
    reset_n = 1'b0;
    drive_slot();
    reset_n    = 1'b1;
    cpu_done   = 1'b1;
    req0_valid = 1'b1;
    req0_instr = 8'h11;
    req1_valid = 1'b1;
    req1_instr = 8'h21;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) drive_slot();
      cpu_result = 8'h30 + 8'(k);
      sample_slot();
      chk("c_idle_ready0", 16'(req0_ready), 16'((k % 2) == 0));
      chk("c_idle_ready1", 16'(req1_ready), 16'((k % 2) == 1));
      chk("c_idle_busy", 16'(busy), 16'h0);
      drive_slot();
      sample_slot();
      chk("c_issue_instr", 16'(cpu_instr), (k % 2) == 0 ? 16'h11 : 16'h21);
      chk("c_issue_ready1", 16'(req1_ready), 16'h0);
      chk("c_issue_rsp_valid", 16'(rsp_valid), 16'h0);
      drive_slot();
      sample_slot();
      chk("c_wait_instr", 16'(cpu_instr), (k % 2) == 0 ? 16'h11 : 16'h21);
      chk("c_wait_ready", 16'({req0_ready, req1_ready}), 16'h0);
      chk("c_wait_rsp_valid", 16'(rsp_valid), 16'h0);
      drive_slot();
      sample_slot();
      chk("c_resp_valid", 16'(rsp_valid), 16'h1);
      chk("c_resp_id", 16'(rsp_id), 16'(k % 2));
      chk("c_resp_result", 16'(rsp_result), 16'h30 + 16'(k));
      chk("c_resp_instr", 16'(cpu_instr), 16'hF0);
      chk("c_resp_ready", 16'({req0_ready, req1_ready}), 16'h0);
    end

    // ---- reset in the middle of WAIT ----
    drive_slot();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_instr = 8'h77;
    cpu_done   = 1'b0;
    sample_slot();
    chk("r_idle_ready1", 16'(req1_ready), 16'h1);
    drive_slot();
    req1_valid = 1'b0;
    drive_slot();
    sample_slot();
    chk("r_wait_instr", 16'(cpu_instr), 16'h77);
    drive_slot();
    reset_n = 1'b0;
    sample_slot();
    chk("r_rst_instr", 16'(cpu_instr), 16'hF0);
    chk("r_rst_busy", 16'(busy), 16'h0);
    chk("r_rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("r_rst_rsp_id", 16'(rsp_id), 16'h0);
    chk("r_rst_rsp_result", 16'(rsp_result), 16'h00);
    drive_slot();
    reset_n  = 1'b1;
    cpu_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_slot();
      chk("r_post_rsp_valid", 16'(rsp_valid), 16'h0);
      chk("r_post_busy", 16'(busy), 16'h0);
      drive_slot();
    end
    cpu_done   = 1'b0;
    req0_valid = 1'b1;
    req0_instr = 8'h44;
    req1_valid = 1'b1;
    req1_instr = 8'h55;
    sample_slot();
    chk("r_tie_ready0", 16'(req0_ready), 16'h1);
    chk("r_tie_ready1", 16'(req1_ready), 16'h0);

    // ---- done never arrives ----
    drive_slot();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sample_slot();
    chk("t_issue_instr", 16'(cpu_instr), 16'h44);
`ifdef CPU_ISSUE_TIMEOUT_EN
    for (int w = 1; w <= 16; w++) begin
      drive_slot();
      sample_slot();
      chk("t_wait_rsp_valid", 16'(rsp_valid), 16'h0);
      chk("t_wait_instr", 16'(cpu_instr), 16'h44);
    end
    drive_slot();
    sample_slot();
    chk("t_resp_valid", 16'(rsp_valid), 16'h1);
    chk("t_resp_timeout", 16'(rsp_timeout), 16'h1);
    chk("t_resp_result", 16'(rsp_result), 16'h00);
    chk("t_resp_id", 16'(rsp_id), 16'h0);
    drive_slot();
    sample_slot();
    chk("t_after_busy", 16'(busy), 16'h0);
`else
    for (int w = 1; w <= 40; w++) begin
      drive_slot();
      sample_slot();
      chk("t_hang_busy", 16'(busy), 16'h1);
      chk("t_hang_rsp_valid", 16'(rsp_valid), 16'h0);
    end
    chk("t_hang_timeout", 16'(rsp_timeout), 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_issue_ctrl.md
# cpu_issue_ctrl

Two-port instruction issue controller for `cpu_top`. It arbitrates 8-bit instructions from two requesters round-robin and drives one instruction at a time onto the CPU `instruction` input. It waits for `done`, captures `result` and returns it to the originating requester with a one-cycle response pulse. Between instructions it parks the CPU on NOP.

## Interface
- `NOP_OPCODE`, 8'hF0, value driven on `cpu_instr` whenever no instruction is in flight
- `TIMEOUT_CYCLES`, 16, WAIT-state cycle limit (used only with the timeout feature); legal range 2..255

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  requester 0 has an instruction
- `req0_instr`  in  8  requester 0 instruction
- `req0_ready`  out  1  requester 0 accepted this cycle
- `req1_valid`, `req1_instr`, `req1_ready`  as above, for requester 1
- `cpu_instr`  out  8  to `cpu_top.instruction`
- `cpu_result`  in  8  from `cpu_top.result`
- `cpu_done`  in  1  from `cpu_top.done`
- `rsp_valid`  out  1  one-cycle response strobe
- `rsp_id`  out  1  requester that owns the response
- `rsp_result`  out  8  captured CPU result
- `rsp_timeout`  out  1  response ended by timeout, not by `done`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values:
  - `cpu_instr`=`NOP_OPCODE`
  - `req*_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=8'h00, `rsp_timeout`=0, `busy`=0
  - round-robin pointer `last`=1, so requester 0 wins the first tie
- IDLE:
  - `readyK` is combinational and is high only for the granted requester.
  - Grant rule: if one requester is valid, it wins. If both are valid, the one not equal to `last` wins.
  - A transfer occurs when `validK && readyK`. On that edge the controller latches the instruction and id, updates `last`=id, and moves to ISSUE.
  - Both ready outputs are 0 in every other state.
- ISSUE: `cpu_instr` = latched instruction for exactly one cycle. `cpu_done` is ignored because it may be stale from the previous instruction. Next state is WAIT.
- WAIT:
  - `cpu_instr` holds the latched instruction.
  - On an edge with `cpu_done`=1, capture `cpu_result` into `rsp_result`, clear `rsp_timeout`, and go to RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle, with `rsp_id`, `rsp_result` and `rsp_timeout` valid.
  - `cpu_instr` returns to `NOP_OPCODE` in this cycle. Next state is IDLE.
  - `rsp_id`, `rsp_result` and `rsp_timeout` hold their values until the next RESP.
- There is no response backpressure. The requester must take the response on `rsp_valid`.
- Only one instruction is in flight at a time. There is no queueing.
- Asynchronous reset in any state drops the in-flight instruction, issues no response, and restores all reset values immediately.

## Timing
- Transfer edge at end of cycle n (IDLE), then:
  - n+1: ISSUE
  - n+2: first WAIT cycle
- If `cpu_done`=1 in cycle n+2, then n+3 is RESP and n+4 is IDLE, where the next transfer is possible.
- Minimum throughput is 4 cycles per instruction. Request-to-response latency is 3 cycles plus (`done` wait − 1).
- With both requesters held valid, grants alternate 0,1,0,1…
- A request arriving while `busy`=1 waits. `readyK` stays 0 and the requester must hold `valid` and `instr` stable.

## Configuration
- `CPU_ISSUE_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` with `cpu_done`=0, go to RESP with `rsp_timeout`=1 and `rsp_result`=8'h00.
  - If `cpu_done`=1 on the same edge that the limit is reached, `done` wins and `rsp_timeout`=0.
- Not defined: the counter is absent, WAIT persists until `cpu_done`, and `rsp_timeout` is tied to 0.

## Test plan
- Single request: `req0_instr`=8'h01, `cpu_done` high in the first WAIT cycle with `cpu_result`=8'h2A → `req0_ready` pulses once, `cpu_instr`=8'h01 for 2 cycles, `rsp_valid` pulses with `rsp_id`=0 and `rsp_result`=8'h2A, then `cpu_instr`=8'hF0.
- Contention: both requesters hold valid (8'h11 and 8'h21) for 4 transactions → grant order 0,1,0,1; each `rsp_id` matches its requester; `req1_ready` stays 0 while busy.
- Stale done: `cpu_done` held at 1 continuously → the ISSUE cycle ignores it and RESP occurs exactly 3 cycles after the transfer edge.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16, `cpu_done`=0) → `rsp_valid` with `rsp_timeout`=1 and `rsp_result`=8'h00 after 16 WAIT cycles. With the macro undefined → `busy` stays 1 indefinitely.
- Reset mid-WAIT: `reset_n` low for 1 cycle → all outputs go to reset values immediately, no `rsp_valid` is produced, and the next tie is granted to requester 0.
